// File: rtl/black_centroid_if.sv
// Pixel-stream and centroid-result bundle for black_centroid_calc.
// Bounding-box members exist only when CENTROID_BBOX_EN is defined.
interface black_centroid_if #(
    parameter int COORD_W = 12
);
    logic               pix_valid;
    logic               pix_black;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               frame_end;
    logic [COORD_W-1:0] x_avg_black;
    logic [COORD_W-1:0] y_avg_black;
    logic               obj_found;
    logic               avg_valid;
    logic               overrun;
    logic               busy;
`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] bbox_xmin;
    logic [COORD_W-1:0] bbox_xmax;
    logic [COORD_W-1:0] bbox_ymin;
    logic [COORD_W-1:0] bbox_ymax;

    modport master (
        output pix_valid, pix_black, pix_x, pix_y, frame_end,
        input  x_avg_black, y_avg_black, obj_found, avg_valid, overrun, busy,
        input  bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );
    modport slave (
        input  pix_valid, pix_black, pix_x, pix_y, frame_end,
        output x_avg_black, y_avg_black, obj_found, avg_valid, overrun, busy,
        output bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
    );
`else
    modport master (
        output pix_valid, pix_black, pix_x, pix_y, frame_end,
        input  x_avg_black, y_avg_black, obj_found, avg_valid, overrun, busy
    );
    modport slave (
        input  pix_valid, pix_black, pix_x, pix_y, frame_end,
        output x_avg_black, y_avg_black, obj_found, avg_valid, overrun, busy
    );
`endif
endinterface

// File: rtl/black_centroid_calc.sv
// Per-frame black-pixel centroid: saturating sums, then two parallel restoring dividers.
// Optional bounding-box tracking is enabled by defining CENTROID_BBOX_EN.
module black_centroid_calc #(
    parameter int COORD_W    = 12,
    parameter int SUM_W      = 32,
    parameter int CNT_W      = 20,
    parameter int MIN_PIXELS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    black_centroid_if.slave bus
);
    typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
    typedef struct packed {
        logic [SUM_W-1:0] rem;
        logic [SUM_W-1:0] quo;
    } div_t;

    localparam int BIT_W = $clog2(SUM_W);

    state_t             state;
    logic [SUM_W-1:0]   sum_x, sum_y, sx_nxt, sy_nxt, divisor;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               div_ok, hit, take;
    div_t               dx, dy;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]   a,
                                                 input logic [COORD_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W+1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    // Remainder stays below the divisor, so SUM_W bits hold it and the low-bit difference is exact.
    function automatic div_t div_step(input div_t d, input logic [SUM_W-1:0] dv);
        logic [SUM_W:0] sh;
        logic           ge;
        div_t           r;
        sh    = {d.rem, d.quo[SUM_W-1]};
        ge    = sh >= {1'b0, dv};
        r.rem = ge ? (sh[SUM_W-1:0] - dv) : sh[SUM_W-1:0];
        r.quo = {d.quo[SUM_W-2:0], ge};
        return r;
    endfunction

`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] xmin_run, xmax_run, ymin_run, ymax_run;
    logic [COORD_W-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
    logic [COORD_W-1:0] xmin_snap, xmax_snap, ymin_snap, ymax_snap;
`endif

    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    always_comb begin
        hit     = bus.pix_valid & bus.pix_black;
        take    = bus.frame_end && (state == ACCUM);
        sx_nxt  = hit ? sat_add(sum_x, bus.pix_x) : sum_x;
        sy_nxt  = hit ? sat_add(sum_y, bus.pix_y) : sum_y;
        cnt_nxt = (hit && (cnt != '1)) ? cnt + 1'b1 : cnt;
`ifdef CENTROID_BBOX_EN
        xmin_nxt = (hit && (bus.pix_x < xmin_run)) ? bus.pix_x : xmin_run;
        xmax_nxt = (hit && (bus.pix_x > xmax_run)) ? bus.pix_x : xmax_run;
        ymin_nxt = (hit && (bus.pix_y < ymin_run)) ? bus.pix_y : ymin_run;
        ymax_nxt = (hit && (bus.pix_y > ymax_run)) ? bus.pix_y : ymax_run;
`endif
    end

    // NOTE: divider and snapshot registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (take) begin
            dx      <= '{rem: '0, quo: sx_nxt};
            dy      <= '{rem: '0, quo: sy_nxt};
            divisor <= SUM_W'(cnt_nxt);
`ifdef CENTROID_BBOX_EN
            xmin_snap <= xmin_nxt;
            xmax_snap <= xmax_nxt;
            ymin_snap <= ymin_nxt;
            ymax_snap <= ymax_nxt;
`endif
        end else if (state == DIVIDE) begin
            dx <= div_step(dx, divisor);
            dy <= div_step(dy, divisor);
        end
    end

    // NOTE: state and outputs use non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ACCUM;
            sum_x           <= '0;
            sum_y           <= '0;
            cnt             <= '0;
            bit_cnt         <= '0;
            div_ok          <= 1'b0;
            bus.x_avg_black <= '0;
            bus.y_avg_black <= '0;
            bus.obj_found   <= 1'b0;
            bus.avg_valid   <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.busy        <= 1'b0;
`ifdef CENTROID_BBOX_EN
            xmin_run      <= '1;
            xmax_run      <= '0;
            ymin_run      <= '1;
            ymax_run      <= '0;
            bus.bbox_xmin <= '0;
            bus.bbox_xmax <= '0;
            bus.bbox_ymin <= '0;
            bus.bbox_ymax <= '0;
`endif
        end else begin
            bus.avg_valid <= 1'b0;
            bus.overrun   <= 1'b0;

            // A frame_end always starts a fresh frame, even when its data is dropped.
            if (bus.frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
`ifdef CENTROID_BBOX_EN
                xmin_run <= '1;
                xmax_run <= '0;
                ymin_run <= '1;
                ymax_run <= '0;
`endif
            end else begin
                sum_x <= sx_nxt;
                sum_y <= sy_nxt;
                cnt   <= cnt_nxt;
`ifdef CENTROID_BBOX_EN
                xmin_run <= xmin_nxt;
                xmax_run <= xmax_nxt;
                ymin_run <= ymin_nxt;
                ymax_run <= ymax_nxt;
`endif
            end

            unique case (state)
                ACCUM: begin
                    if (bus.frame_end) begin
                        if (cnt_nxt >= CNT_W'(MIN_PIXELS)) begin
                            state    <= DIVIDE;
                            bus.busy <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            state  <= DONE;
                            div_ok <= 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    bus.overrun <= bus.frame_end;
                    if (bit_cnt == BIT_W'(SUM_W - 1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        div_ok   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.overrun   <= bus.frame_end;
                    bus.avg_valid <= 1'b1;
                    bus.obj_found <= div_ok;
                    if (div_ok) begin
                        bus.x_avg_black <= dx.quo[COORD_W-1:0];
                        bus.y_avg_black <= dy.quo[COORD_W-1:0];
`ifdef CENTROID_BBOX_EN
                        bus.bbox_xmin <= xmin_snap;
                        bus.bbox_xmax <= xmax_snap;
                        bus.bbox_ymin <= ymin_snap;
                        bus.bbox_ymax <= ymax_snap;
`endif
                    end
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_black_centroid_calc.sv
// Scoreboard bench for black_centroid_calc: expected results queued at frame_end,
// compared (value, latency, busy length) when avg_valid strobes.
module tb_black_centroid_calc;
    localparam int COORD_W = 12;
    localparam int SUM_W   = 32;
    localparam int MINP    = 16;

    typedef struct {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               found;
        int                 due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    black_centroid_if #(.COORD_W(COORD_W)) bus ();

    black_centroid_calc #(
        .COORD_W    (COORD_W),
        .SUM_W      (SUM_W),
        .CNT_W      (20),
        .MIN_PIXELS (MINP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                 total = 0;
    int                 bad   = 0;
    exp_t               sb[$];
    int                 ovr_q[$];
    longint             m_sx, m_sy;
    int                 m_cnt;
    logic [COORD_W-1:0] last_x, last_y;
    int                 last_due;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else begin
                if (bus.busy) busy_run++;
                if (bus.avg_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_avg_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("x_avg", bus.x_avg_black, e.x);
                        check("y_avg", bus.y_avg_black, e.y);
                        check("obj_found", bus.obj_found, e.found);
                        check("latency", cyc, e.due);
                        check("busy_len", busy_run, e.found ? SUM_W : 0);
                    end
                    busy_run = 0;
                end
                if (bus.overrun) begin
                    if (ovr_q.size() == 0) check("spurious_overrun", 1, 0);
                    else                   check("overrun_cycle", cyc, ovr_q.pop_front());
                end
            end
        end
    end

    // One pixel cycle; on frame_end the model either queues a result or expects an overrun.
    task automatic px(input logic v, input logic b, input int x, input int y, input logic fe);
        bus.pix_valid = v;
        bus.pix_black = b;
        bus.pix_x     = x[COORD_W-1:0];
        bus.pix_y     = y[COORD_W-1:0];
        bus.frame_end = fe;
        if (v && b) begin
            m_sx  += x;
            m_sy  += y;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_black = 1'b0;
        bus.frame_end = 1'b0;
        if (fe) begin
            if (cyc <= last_due) begin
                ovr_q.push_back(cyc);
            end else begin
                exp_t e;
                e.found = (m_cnt >= MINP);
                e.x     = e.found ? COORD_W'(m_sx / m_cnt) : last_x;
                e.y     = e.found ? COORD_W'(m_sy / m_cnt) : last_y;
                e.due   = cyc + (e.found ? SUM_W + 1 : 1);
                last_x   = e.x;
                last_y   = e.y;
                last_due = e.due;
                sb.push_back(e);
            end
            m_sx  = 0;
            m_sy  = 0;
            m_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        if (sb.size() != 0) begin
            check("timeout_pending", sb.size(), 0);
            sb.delete();
        end
        idle(2);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        ovr_q.delete();
        m_sx     = 0;
        m_sy     = 0;
        m_cnt    = 0;
        last_x   = '0;
        last_y   = '0;
        last_due = cyc;
        check("rst_x_avg", bus.x_avg_black, 0);
        check("rst_y_avg", bus.y_avg_black, 0);
        check("rst_obj_found", bus.obj_found, 0);
        check("rst_avg_valid", bus.avg_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    task automatic frame_const(input int n, input int x, input int y);
        repeat (n) px(1'b1, 1'b1, x, y, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_black = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.frame_end = 1'b0;
        m_sx = 0; m_sy = 0; m_cnt = 0;
        last_x = '0; last_y = '0; last_due = 0;

        do_reset(3);

        // 16 pixels at one point; non-black and invalid pixels must be ignored.
        frame_const(8, 100, 200);
        px(1'b1, 1'b0, 999, 700, 1'b0);
        px(1'b0, 1'b1, 999, 700, 1'b0);
        frame_const(8, 100, 200);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        // Extremes of the row: truncated 639.5.
        frame_const(8, 0, 719);
        frame_const(8, 1279, 719);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        // One pixel short: no object, previous centroid held.
        frame_const(15, 5, 5);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        // Pixel in the frame_end cycle belongs to the ending frame.
        frame_const(15, 10, 10);
        px(1'b1, 1'b1, 26, 10, 1'b1);
        wait_done();

        // Second frame_end during DIVIDE is dropped with an overrun pulse.
        frame_const(16, 300, 400);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        frame_const(9, 50, 60);
        px(1'b1, 1'b1, 50, 60, 1'b1);
        wait_done();
        frame_const(8, 7, 9);
        frame_const(8, 9, 13);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        // Random frame.
        for (int i = 0; i < 60; i++)
            px(($urandom_range(0, 3) != 0), 1'(($urandom_range(0, 1))),
               int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1'b0);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        // Reset mid-DIVIDE aborts with no strobe; the next frame still works.
        frame_const(20, 1, 2);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        idle(10);
        do_reset(1);
        idle(45);
        frame_const(16, 33, 44);
        px(1'b0, 1'b0, 0, 0, 1'b1);
        wait_done();

        check("overrun_missing", ovr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
